// File: rtl/countdown_mm_ss_if.sv
// Bus between the keypad entry stage / display side and the countdown_mm_ss cook-time counter.
// The slave modport is the counter's view; master is the driver (entry stage or bench).
interface countdown_mm_ss_if;
  logic       loadn;
  logic [3:0] units_of_seconds;
  logic [3:0] tens_of_seconds;
  logic [3:0] units_of_minutes;
  logic       pgt_1Hz;
  logic       count_en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       zero;
  logic       done;
  logic [1:0] state;

  modport slave (
    input  loadn, units_of_seconds, tens_of_seconds, units_of_minutes, pgt_1Hz, count_en,
    output sec_ones, sec_tens, min_ones, zero, done, state
  );

  modport master (
    output loadn, units_of_seconds, tens_of_seconds, units_of_minutes, pgt_1Hz, count_en,
    input  sec_ones, sec_tens, min_ones, zero, done, state
  );
endinterface

// File: rtl/countdown_mm_ss.sv
// Microwave cook-time M:SS down-counter with keypad parallel load, tick divider and done pulse.
// Optional macro LEADING_BLANK_EN drives BLANK_CODE on leading-zero display digits.
module countdown_mm_ss #(
  parameter int         TICK_DIV   = 1,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  countdown_mm_ss_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

  state_e     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [7:0] div_q, div_d;
  logic       done_q, done_d;
  logic       pgt_q;

  logic       tick;
  logic       count_zero;
  logic       count_one;
  logic [3:0] ld_sec_ones;
  logic [3:0] ld_sec_tens;
  logic [3:0] ld_min_ones;
  logic       ld_nonzero;

  // Entry-stage digits may be blank or out of BCD range; clamp them to a legal time.
  function automatic logic [3:0] norm_units(input logic [3:0] d);
    if (d == BLANK_CODE)  return 4'd0;
    else if (d > 4'd9)    return 4'd9;
    else                  return d;
  endfunction

  function automatic logic [3:0] norm_tens(input logic [3:0] d);
    if (d == BLANK_CODE)  return 4'd0;
    else if (d > 4'd5)    return 4'd5;
    else                  return d;
  endfunction

  assign ld_sec_ones = norm_units(bus.units_of_seconds);
  assign ld_sec_tens = norm_tens(bus.tens_of_seconds);
  assign ld_min_ones = norm_units(bus.units_of_minutes);
  assign ld_nonzero  = (ld_sec_ones != 4'd0) || (ld_sec_tens != 4'd0) || (ld_min_ones != 4'd0);

  assign tick       = bus.pgt_1Hz & ~pgt_q;
  assign count_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (min_ones_q == 4'd0);
  assign count_one  = (sec_ones_q == 4'd1) && (sec_tens_q == 4'd0) && (min_ones_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      div_q      <= 8'd0;
      done_q     <= 1'b0;
      pgt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      div_q      <= div_d;
      done_q     <= done_d;
      pgt_q      <= bus.pgt_1Hz;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    div_d      = div_q;
    done_d     = 1'b0;

    if (!bus.loadn) begin
      sec_ones_d = ld_sec_ones;
      sec_tens_d = ld_sec_tens;
      min_ones_d = ld_min_ones;
      div_d      = 8'd0;
      state_d    = ld_nonzero ? ST_ARMED : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ARMED: begin
          if (bus.count_en) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A pause wins over a same-cycle tick; the divider phase is kept for resume.
          if (!bus.count_en) begin
            state_d = ST_ARMED;
          end else if (tick) begin
            if (div_q == DIV_LAST) begin
              div_d = 8'd0;
              if (count_one) begin
                sec_ones_d = 4'd0;
                done_d     = 1'b1;
                state_d    = ST_DONE;
              end else if (!count_zero) begin
                if (sec_ones_q != 4'd0) begin
                  sec_ones_d = sec_ones_q - 4'd1;
                end else begin
                  sec_ones_d = 4'd9;
                  if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                  end else begin
                    sec_tens_d = 4'd5;
                    min_ones_d = min_ones_q - 4'd1;
                  end
                end
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (!bus.count_en) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef LEADING_BLANK_EN
  always_comb begin
    bus.sec_ones = sec_ones_q;
    bus.sec_tens = sec_tens_q;
    bus.min_ones = min_ones_q;
    if (min_ones_q == 4'd0) begin
      bus.min_ones = BLANK_CODE;
      if (sec_tens_q == 4'd0) bus.sec_tens = BLANK_CODE;
    end
  end
`else
  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.min_ones = min_ones_q;
`endif

  assign bus.zero  = count_zero;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule
